// File: rtl/sdram_line_scheduler.sv
// Arbitrates the single-line SDRAM controller between VGA line fetch (read, priority) and frame-draw writes.
// Latency: dispatch 1 cycle after request seen idle, START 2 cycles, then waits on mc_done edge; disp_valid 1 cycle after COMPLETE.
// Backpressure: writer holds wr_req until wr_ack; display requests never stall, extras raise disp_overrun.
// Ports: disp_* display fetch side, wr_* writer side, swap_req/front_bank double-buffer control,
//        mc_* memoryController interface, timeout_err sticky abort flag.
module sdram_line_scheduler #(
  parameter int LINE_W  = 1696,
  parameter int ROW_W   = 9,
  parameter int TIMEOUT = 4095
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              disp_req,
  input  logic [ROW_W-1:0]  disp_row,
  output logic [LINE_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic              wr_req,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              swap_req,
  output logic              front_bank,
  output logic              timeout_err,
  output logic              mc_start,
  output logic              mc_write,
  output logic [ROW_W-1:0]  mc_row,
  output logic [1:0]        mc_bank,
  output logic [LINE_W-1:0] mc_wdata,
  input  logic [LINE_W-1:0] mc_rdata,
  input  logic              mc_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             pend;
  logic [ROW_W-1:0] pend_row;
  logic             swap_pend;
  logic             done_q;
  logic             bank_q;

  logic             disp_any;
  logic             swap_now;
  logic             read_active;
  logic             dispatch_rd;
  logic             dispatch_wr;
  logic             timed_out;

  // A display request arriving in the idle cycle itself is served at once,
  // so it beats a write that is already waiting.
  assign disp_any    = pend | disp_req;
  // A latched swap takes effect in any idle cycle, before the dispatch made
  // in that same cycle, so the dispatched transfer already sees the new bank.
  assign swap_now    = (state == IDLE) & (swap_pend | swap_req);
  assign read_active = (state != IDLE) & ~mc_write;
  assign mc_bank     = {1'b0, bank_q};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mc_start    = 1'b0;
    wr_ack      = 1'b0;
    dispatch_rd = 1'b0;
    dispatch_wr = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE: begin
        if (disp_any) begin
          dispatch_rd = 1'b1;
          state_nxt   = START;
        end else if (wr_req) begin
          dispatch_wr = 1'b1;
          state_nxt   = START;
        end
      end
      START: begin
        mc_start = 1'b1;
        if (cnt == CW'(1)) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Done may still be high from the previous operation; it must fall first.
        if (cnt == CW'(TIMEOUT)) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
        end else if (!mc_done) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mc_done && !done_q) begin
          state_nxt = COMPLETE;
        end else if (cnt == CW'(TIMEOUT)) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMPLETE: begin
        wr_ack    = mc_write;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An aborted write is still acknowledged so the writer never stalls.
    if (timed_out && mc_write) wr_ack = 1'b1;
  end

  // One counter times both the 2-cycle start pulse and the Done wait; it
  // restarts at 0 when the wait begins and never exceeds TIMEOUT there.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else begin
      case (state)
        START:               cnt <= (cnt == CW'(1)) ? '0 : cnt + CW'(1);
        WAIT_LOW, WAIT_DONE: cnt <= cnt + CW'(1);
        default:             cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_q      <= 1'b0;
      timeout_err <= 1'b0;
      front_bank  <= 1'b0;
      swap_pend   <= 1'b0;
    end else begin
      done_q      <= mc_done;
      timeout_err <= timeout_err | timed_out;
      front_bank  <= front_bank ^ swap_now;
      swap_pend   <= swap_now ? 1'b0 : (swap_pend | swap_req);
    end
  end

  // Transfer parameters are loaded on dispatch and stay constant until the
  // next dispatch, covering START through COMPLETE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mc_write <= 1'b0;
      mc_row   <= '0;
      bank_q   <= 1'b0;
      mc_wdata <= '0;
    end else if (dispatch_rd) begin
      mc_write <= 1'b0;
      mc_row   <= disp_req ? disp_row : pend_row;
      bank_q   <= front_bank ^ swap_now;
    end else if (dispatch_wr) begin
      mc_write <= 1'b1;
      mc_row   <= wr_row;
      bank_q   <= ~(front_bank ^ swap_now);
      mc_wdata <= wr_data;
    end
  end

  // The pending flag holds at most one queued fetch; a newer request replaces
  // the queued row. The fetch in flight is tracked by the FSM, not by pend.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend         <= 1'b0;
      pend_row     <= '0;
      disp_overrun <= 1'b0;
    end else begin
      disp_overrun <= disp_req & (pend | read_active);
      if (disp_req) pend_row <= disp_row;
      if (dispatch_rd)                pend <= 1'b0;
      else if (disp_req)              pend <= 1'b1;
      else if (timed_out && !mc_write) pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_valid <= (state == COMPLETE) & ~mc_write;
      if ((state == COMPLETE) && !mc_write) disp_data <= mc_rdata;
    end
  end

endmodule

// File: tb/tb_sdram_line_scheduler.sv
// Scoreboard bench for sdram_line_scheduler: issued requests push expected
// controller transfers and completions; a monitor pops them as the DUT acts.
// Reference model: a double-buffered line memory plus front-bank tracking.
module tb_sdram_line_scheduler;
  localparam int LINE_W  = 1696;
  localparam int ROW_W   = 9;
  localparam int TIMEOUT = 4095;
  localparam int NW      = LINE_W / 32;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              disp_req = 1'b0;
  logic [ROW_W-1:0]  disp_row = '0;
  logic [LINE_W-1:0] disp_data;
  logic              disp_valid, disp_overrun;
  logic              wr_req = 1'b0;
  logic [ROW_W-1:0]  wr_row = '0;
  logic [LINE_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic              swap_req = 1'b0;
  logic              front_bank, timeout_err;
  logic              mc_start, mc_write;
  logic [ROW_W-1:0]  mc_row;
  logic [1:0]        mc_bank;
  logic [LINE_W-1:0] mc_wdata;
  logic [LINE_W-1:0] mc_rdata = '0;
  logic              mc_done = 1'b0;

  always #5 CLK = ~CLK;

  sdram_line_scheduler #(.LINE_W(LINE_W), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .disp_req(disp_req), .disp_row(disp_row), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_overrun(disp_overrun),
    .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data), .wr_ack(wr_ack),
    .swap_req(swap_req), .front_bank(front_bank), .timeout_err(timeout_err),
    .mc_start(mc_start), .mc_write(mc_write), .mc_row(mc_row), .mc_bank(mc_bank),
    .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_done(mc_done)
  );

  typedef struct packed {
    logic              w;
    logic [ROW_W-1:0]  row;
    logic              b;
    logic [LINE_W-1:0] d;
  } exp_t;

  exp_t              exp_xfer[$];
  exp_t              exp_cmp[$];
  logic [LINE_W-1:0] ref_mem[int];
  logic [LINE_W-1:0] phys_mem[int];
  int cmp_cnt = 0, fail_cnt = 0, ovr_cnt = 0, cyc = 0;
  int start_cyc = 0, ack_cyc = 0;
  logic front_m = 1'b0;

  int mc_lo = 3, mc_hi = 20, stale_hold = 0;
  bit stuck = 0, fresh = 0;

  always @(posedge CLK) cyc++;

  function automatic logic [LINE_W-1:0] pat(int key);
    logic [LINE_W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = (32'(key) * 32'h9E37_79B1) ^ 32'(i * 7919);
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int key_of(logic b, logic [ROW_W-1:0] row);
    return int'(b) * 512 + int'(row);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_wide(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got low word %08h expected low word %08h (cycle %0d)",
               name, act[31:0], exp[31:0], cyc);
    end
  endtask

  // memoryController model: Done falls some cycles after start (stale hold),
  // rises after a random delay, then stays high until the next start.
  int wait_n = 0, stale_n = 0;
  bit busy = 0, cw = 0, cb = 0;
  logic [ROW_W-1:0]  crow = '0;
  logic [LINE_W-1:0] cwd = '0;
  always @(posedge CLK) begin
    #1;
    if (mc_start) begin
      busy = 1; fresh = 0;
      wait_n = $urandom_range(mc_hi, mc_lo);
      stale_n = stale_hold;
      cw = mc_write; crow = mc_row; cb = mc_bank[0]; cwd = mc_wdata;
    end else if (busy) begin
      if (mc_done) begin
        if (stale_n > 0) stale_n--;
        else mc_done = 1'b0;
      end else if (!stuck) begin
        if (wait_n > 0) wait_n--;
        else begin
          if (cw) phys_mem[key_of(cb, crow)] = cwd;
          else mc_rdata = phys_mem.exists(key_of(cb, crow)) ? phys_mem[key_of(cb, crow)]
                                                            : pat(key_of(cb, crow));
          mc_done = 1'b1; fresh = 1; busy = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts or completes a transfer.
  bit start_prev = 0;
  int start_len = 0;
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET_N) begin
      if (mc_start) begin
        if (!start_prev) begin
          start_cyc = cyc; start_len = 0;
          if (exp_xfer.size() == 0) check("xfer_unexpected", 64'(mc_row), 64'hFFFF);
          else begin
            e = exp_xfer.pop_front();
            check("xfer_write", 64'(mc_write), 64'(e.w));
            check("xfer_row", 64'(mc_row), 64'(e.row));
            check("xfer_bank", 64'(mc_bank), 64'({1'b0, e.b}));
            if (e.w) check_wide("xfer_wdata", mc_wdata, e.d);
          end
        end
        start_len++;
      end else if (start_prev) begin
        check("start_len", 64'(start_len), 64'd2);
      end
      start_prev = mc_start;
      if (disp_valid) begin
        if (exp_cmp.size() == 0) check("disp_valid_unexpected", 64'(disp_valid), 64'd0);
        else begin
          e = exp_cmp.pop_front();
          check("cmp_kind_read", 64'(e.w), 64'd0);
          check_wide("disp_data", disp_data, e.d);
          check("read_done_fresh", 64'(fresh), 64'd1);
        end
      end
      if (wr_ack) begin
        ack_cyc = cyc;
        if (exp_cmp.size() == 0) check("wr_ack_unexpected", 64'(wr_ack), 64'd0);
        else begin
          e = exp_cmp.pop_front();
          check("cmp_kind_write", 64'(e.w), 64'd1);
          if (!stuck) check("write_done_fresh", 64'(fresh), 64'd1);
        end
      end
      if (disp_overrun) ovr_cnt++;
    end else begin
      start_prev = 0;
    end
  end

  task automatic step();
    @(negedge CLK);
    disp_req = 1'b0;
    swap_req = 1'b0;
    if (wr_ack) wr_req = 1'b0;
  endtask

  task automatic issue_read(int row);
    exp_t e;
    e.w = 1'b0; e.row = ROW_W'(row); e.b = front_m;
    e.d = ref_mem.exists(key_of(front_m, e.row)) ? ref_mem[key_of(front_m, e.row)]
                                                  : pat(key_of(front_m, e.row));
    exp_xfer.push_back(e);
    exp_cmp.push_back(e);
    disp_req = 1'b1; disp_row = ROW_W'(row);
  endtask

  task automatic issue_write(int row, logic [LINE_W-1:0] d, bit commit);
    exp_t e;
    e.w = 1'b1; e.row = ROW_W'(row); e.b = ~front_m; e.d = d;
    exp_xfer.push_back(e);
    exp_cmp.push_back(e);
    if (commit) ref_mem[key_of(~front_m, e.row)] = d;
    wr_req = 1'b1; wr_row = ROW_W'(row); wr_data = d;
  endtask

  task automatic issue_swap();
    front_m = ~front_m;
    swap_req = 1'b1;
  endtask

  task automatic wait_quiet(string name, int budget);
    int n = 0;
    while ((exp_cmp.size() != 0 || wr_req) && n < budget) begin
      step(); n++;
    end
    check(name, 64'(n < budget), 64'd1);
    repeat (3) step();
  endtask

  task automatic wait_start(string name);
    int n = 0;
    while (!mc_start && n < 50) begin
      step(); n++;
    end
    check(name, 64'(mc_start), 64'd1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_mc_start"}, 64'(mc_start), 64'd0);
    check({tag, "_mc_write"}, 64'(mc_write), 64'd0);
    check({tag, "_mc_row"}, 64'(mc_row), 64'd0);
    check({tag, "_mc_bank"}, 64'(mc_bank), 64'd0);
    check({tag, "_front_bank"}, 64'(front_bank), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, "_disp_valid"}, 64'(disp_valid), 64'd0);
    check({tag, "_disp_overrun"}, 64'(disp_overrun), 64'd0);
    check({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
    check({tag, "_disp_data"}, 64'(disp_data[63:0]), 64'd0);
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    repeat (3) step();
    check_all_zero("reset");
    RESET_N = 1'b1;
    step();

    // 1: single fetch, fixed 20-cycle controller
    mc_lo = 20; mc_hi = 20;
    issue_read(37); step();
    wait_quiet("t1_done", 300);

    // 2: same-cycle tie, display first, write to back bank
    mc_lo = 3; mc_hi = 12;
    issue_read(50); issue_write(100, rand_line(), 1); step();
    wait_quiet("t2_done", 300);
    check("t2_overrun", 64'(ovr_cnt), 64'd0);

    // 3a: fetch requested during a write waits for it
    issue_write(200, rand_line(), 1); step();
    wait_start("t3_write_start"); step();
    issue_read(201); step();
    wait_quiet("t3a_done", 300);
    check("t3a_overrun", 64'(ovr_cnt), 64'd0);
    // 3b: two requests during a fetch, only the latest survives
    issue_read(10); step();
    wait_start("t3_read_start"); step();
    disp_req = 1'b1; disp_row = ROW_W'(11); step();
    issue_read(12); step();
    wait_quiet("t3b_done", 300);
    check("t3b_overrun", 64'(ovr_cnt), 64'd2);

    // 4: swap while a fetch is in flight
    issue_read(60); step();
    wait_start("t4_read_start"); step();
    issue_swap(); step();
    wait_quiet("t4_r60", 300);
    issue_read(61); step(); wait_quiet("t4_r61", 300);
    d = rand_line();
    issue_write(62, d, 1); step(); wait_quiet("t4_w62", 300);
    issue_read(100); step(); wait_quiet("t4_r100", 300);
    issue_swap(); step();
    issue_read(62); step(); wait_quiet("t4_r62", 300);
    check("t4_front", 64'(front_bank), 64'(front_m));

    // 5: stale Done held high across the start
    stale_hold = 10;
    issue_read(70); step(); wait_quiet("t5_read", 300);
    issue_write(71, rand_line(), 1); step(); wait_quiet("t5_write", 300);
    stale_hold = 0;

    // random traffic against the double-buffer model
    mc_lo = 1; mc_hi = 15;
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(9, 0);
      stale_hold = $urandom_range(3, 0);
      if (r < 4)      begin issue_read($urandom_range(7, 0)); step(); end
      else if (r < 8) begin issue_write($urandom_range(7, 0), rand_line(), 1); step(); end
      else            begin issue_swap(); step(); end
      wait_quiet("rand_done", 300);
    end
    stale_hold = 0;
    check("rand_front", 64'(front_bank), 64'(front_m));
    check("rand_no_timeout", 64'(timeout_err), 64'd0);
    check("rand_overrun", 64'(ovr_cnt), 64'd2);

    // 6: Done stuck low -> abort, wr_ack, sticky error
    stuck = 1;
    issue_write(5, rand_line(), 0); step();
    wait_quiet("t6_abort", TIMEOUT + 200);
    check("t6_timeout_err", 64'(timeout_err), 64'd1);
    check("t6_wait_ge_timeout", 64'((ack_cyc - start_cyc) >= TIMEOUT), 64'd1);
    check("t6_wait_bounded", 64'((ack_cyc - start_cyc) <= TIMEOUT + 10), 64'd1);
    stuck = 0;
    issue_read(3); step(); wait_quiet("t6_recover", 300);
    check("t6_err_sticky", 64'(timeout_err), 64'd1);

    // reset in the middle of a transfer
    if (front_m == 1'b0) begin issue_swap(); step(); end
    issue_read(4); step();
    repeat (6) step();
    RESET_N = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_xfer.delete(); exp_cmp.delete();
    front_m = 1'b0;
    repeat (2) step();
    RESET_N = 1'b1;
    step();
    issue_read(6); step(); wait_quiet("post_reset_read", 300);
    check("post_reset_front", 64'(front_bank), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
